data_mem_ctrl: RTL
==================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DATA_W, 32: data and address width.
REQ-002 Parameter TIMEOUT_CYCLES, 16: wait-for-ack limit; used only when MEM_TIMEOUT_EN is defined.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 MemRead  in  1  load request from the main decoder's MemRead control output.
REQ-006 MemWrite  in  1  store request from the main decoder's MemWrite control output.
REQ-007 Funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores: 000/001/010 only).
REQ-008 Addr  in  DATA_W  byte address computed by the ALU.
REQ-009 WrData  in  DATA_W  store data, right-aligned.
REQ-010 RdData  out  DATA_W  aligned, extended load result.
REQ-011 Stall  out  1  high while the pipeline must hold the current memory instruction.
REQ-012 Err  out  1  one-cycle pulse on a misaligned, illegal or timed-out access.
REQ-013 mem_req  out  1  memory-side request, held until accepted.
REQ-014 mem_we  out  1  1 = write, 0 = read.
REQ-015 mem_addr  out  DATA_W  word address: Addr with bits [1:0] forced to 0.
REQ-016 mem_be  out  4  byte enables.
REQ-017 mem_wdata  out  DATA_W  store data replicated into byte lanes.
REQ-018 mem_ack  in  1  memory accepted the request; mem_rdata is valid in this cycle.
REQ-019 mem_rdata  in  DATA_W  read word.

Function
REQ-020 FSM states: IDLE, REQ, DONE.
- IDLE to REQ when (MemRead xor MemWrite) and the access is legal; Addr, Funct3, mem_be, mem_wdata and mem_we are latched on that transition.
REQ-021 REQ to DONE on mem_ack; for reads, the aligned result is captured into RdData on that edge.
- DONE to IDLE unconditionally after one cycle.
REQ-022 mem_req = (state==REQ); all mem_* outputs stay stable from request until ack.
REQ-023 Stall = (IDLE and legal request pending) or (state==REQ); Stall is low in DONE.
- Zero-wait memory gives 2 stall cycles (request seen in cycle 0, ack in cycle 1, Stall low in cycle 2).
REQ-024 Byte enables:
- B: 0001 shifted left by Addr[1:0].
- H: 0011 shifted left by 2*Addr[1].
- W: 1111.
REQ-025 Load extraction: select the addressed byte or halfword; sign-extend for B/H, zero-extend for BU/HU.
REQ-026 Illegal accesses: H with Addr[0]=1, W with Addr[1:0]!=0, a reserved Funct3, or MemRead and MemWrite both high.
- Response: Err pulses in that same cycle, no mem_req, Stall low, RdData unchanged, state stays IDLE.
REQ-027 RdData holds its last loaded value until the next successful load completes.
- Stores never modify RdData.
REQ-028 A memory op presented in DONE is ignored; the same op is seen again in IDLE on the following cycle, so back-to-back ops are serviced without loss.
REQ-029 mem_ack outside REQ is ignored.

Reset
REQ-030 Reset asserted (including mid-transaction) forces immediately:
- state=IDLE
- mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0
- RdData=0, Err=0
- Stall then follows the inputs per REQ-023.

Configuration
REQ-031 Macro MEM_TIMEOUT_EN defined: a counter runs in REQ. After TIMEOUT_CYCLES cycles without ack:
- go to DONE.
- pulse Err.
- load RdData=0.
- Macro undefined: no counter; REQ waits indefinitely for ack.

Structure
REQ-032 Package mem_ctrl_pkg holds:
- the state enum.
- Funct3 size constants.
- a byte-enable width constant.
REQ-033 Sub-module load_align (combinational): mem_rdata, Addr[1:0], Funct3 -> extended RdData value.

Verification
REQ-034 LW Addr=0x100, mem_ack in the first REQ cycle, mem_rdata=0xDEADBEEF -> Stall high for 2 cycles, then RdData=0xDEADBEEF.
REQ-035 LB Addr=0x103, mem_rdata=0x80112233 -> mem_be=1000, RdData=0xFFFFFF80; the same access with LBU -> RdData=0x00000080.
REQ-036 SH Addr=0x202, WrData=0x0000ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x200.
REQ-037 LW Addr=0x101 -> Err pulses 1 cycle, mem_req never asserts, Stall=0.
REQ-038 LW with mem_ack held low and reset asserted in cycle 3 of REQ -> mem_req drops immediately, state IDLE, RdData=0.
REQ-039 With MEM_TIMEOUT_EN defined and mem_ack never asserted -> after 16 REQ cycles Err pulses, RdData=0, Stall drops.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the data memory controller: FSM states,
// Funct3 access-size encodings, byte-enable width and per-access decode helpers.
package mem_ctrl_pkg;

  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Size/sign encoding valid for the direction and naturally aligned.
  function automatic logic access_legal(input logic [2:0] funct3,
                                        input logic [1:0] addr_lo,
                                        input logic       is_store);
    case (funct3)
      F3_B:    return 1'b1;
      F3_H:    return !addr_lo[0];
      F3_W:    return addr_lo == 2'b00;
      F3_BU:   return !is_store;
      F3_HU:   return !is_store && !addr_lo[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [BE_W-1:0] byte_enables(input logic [2:0] funct3,
                                                   input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b00:   return BE_W'(4'b0001 << addr_lo);
      2'b01:   return BE_W'(4'b0011 << {addr_lo[1], 1'b0});
      default: return {BE_W{1'b1}};
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_load_align.sv
// load_align: picks the addressed byte/halfword out of a read word and
// sign- or zero-extends it according to Funct3.
module load_align
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        addr_lo,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every output of a combinational block gets a value before any
    // branch; otherwise an uncovered path would infer a latch.
    byte_sel = rdata[7:0];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    data     = rdata;
    case (addr_lo)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    case (funct3)
      F3_B:    data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      F3_BU:   data = {{(DATA_W-8){1'b0}}, byte_sel};
      F3_H:    data = {{(DATA_W-16){half_sel[15]}}, half_sel};
      F3_HU:   data = {{(DATA_W-16){1'b0}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store unit between the pipeline and a req/ack data memory.
// Optional feature: define MEM_TIMEOUT_EN to abort a request after TIMEOUT_CYCLES.
module data_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        Funct3,
  input  logic [DATA_W-1:0] Addr,
  input  logic [DATA_W-1:0] WrData,
  output logic [DATA_W-1:0] RdData,
  output logic              Stall,
  output logic              Err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [BE_W-1:0]   mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] load_data;
  logic              req_legal, req_illegal, err_pulse;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .rdata   (mem_rdata),
    .addr_lo (addr_lo_q),
    .funct3  (funct3_q),
    .data    (load_data)
  );

  always_comb begin
    req_legal   = (MemRead ^ MemWrite) && access_legal(Funct3, Addr[1:0], MemWrite);
    req_illegal = (MemRead | MemWrite) && !req_legal;
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    addr_lo_d   = addr_lo_q;
    funct3_d    = funct3_q;
    rd_data_d   = rd_data_q;
    err_pulse   = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d = (state_q == ST_REQ) ? cnt_q + 1'b1 : '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_legal) begin
          state_d    = ST_REQ;
          mem_we_d   = MemWrite;
          mem_be_d   = byte_enables(Funct3, Addr[1:0]);
          mem_addr_d = {Addr[DATA_W-1:2], 2'b00};
          addr_lo_d  = Addr[1:0];
          funct3_d   = Funct3;
          case (Funct3[1:0])
            2'b00:   mem_wdata_d = DATA_W'({4{WrData[7:0]}});
            2'b01:   mem_wdata_d = DATA_W'({2{WrData[15:0]}});
            default: mem_wdata_d = WrData;
          endcase
        end else if (req_illegal) begin
          err_pulse = 1'b1;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          state_d = ST_DONE;
          if (!mem_we_q) rd_data_d = load_data;
`ifdef MEM_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = ST_DONE;
          err_pulse = 1'b1;
          if (!mem_we_q) rd_data_d = '0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      addr_lo_q   <= '0;
      funct3_q    <= '0;
      rd_data_q   <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      addr_lo_q   <= addr_lo_d;
      funct3_q    <= funct3_d;
      rd_data_q   <= rd_data_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Err is combinational from the request inputs, so it is masked while reset is held.
  assign Err       = err_pulse & ~reset;
  assign Stall     = (state_q == ST_IDLE && req_legal) || (state_q == ST_REQ);
  assign mem_req   = (state_q == ST_REQ);
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign RdData    = rd_data_q;

endmodule
